run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
- Parametrised one-hot Moore FSM that watches a serial bit `w` and asserts `z` once the last RUN_LEN accepted bits are all equal.
- Generalises the fixed two-in-a-row detector in four ways: run length, polarity mode select, clock enable, and a saturating detection counter.
- Adds illegal-state recovery.
- Sits in the lab FSM datapath, driving LEDs and display logic from switch/button inputs.

Parameters:
- RUN_LEN, 2, required run length; legal range 2..16. Elaboration error outside this range.
- CNT_W, 8, width of match_cnt; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; forces IDLE and clears the counter.
- en  input  1  sample enable; when 0, state and counter hold.
- w  input  1  serial data bit, sampled when en=1.
- mode  input  2  00=detect either polarity, 01=zeros only, 10=ones only, 11=either (same as 00).
- clear_cnt  input  1  synchronous counter clear.
- z  output  1  detection flag (Moore, registered state gated by mode).
- z_val  output  1  polarity of current saturated run: 1=ones, 0=zeros; 0 when no saturated run.
- State  output  2*RUN_LEN+1  one-hot state vector.
- match_cnt  output  CNT_W  saturating count of new detections.

Behaviour:
- State indices:
  - 0 = IDLE.
  - k (1..RUN_LEN) = Zk, meaning the current run is k zeros.
  - RUN_LEN+k = Ok, meaning the current run is k ones.
  - With RUN_LEN=2 this gives IDLE, Z1, Z2, O1, O2 at bits 0..4.
- Reset (sync, highest priority): State=1 (IDLE only), match_cnt=0. As a consequence z=0 and z_val=0 in the following cycle. Reset mid-run discards the run.
- Transitions occur only on edges where en=1:
  - w=0: from IDLE or any Ok go to Z1; from Zk go to Z(min(k+1,RUN_LEN)).
  - w=1: from IDLE or any Zk go to O1; from Ok go to O(min(k+1,RUN_LEN)).
  - The run length saturates at RUN_LEN, so the FSM stays in Z_RUN_LEN or O_RUN_LEN while input repeats.
- en=0: State holds and match_cnt holds. reset and clear_cnt still act.
- IDLE is never re-entered except by reset or recovery.
- Illegal-state recovery: if State is not exactly one-hot (zero or multiple bits set), the next state is IDLE on the next edge, regardless of en. The counter does not increment on that edge.
- Outputs are combinational from State and mode:
  - z = (State[RUN_LEN] & mode!=10) | (State[2*RUN_LEN] & mode!=01).
  - z_val = State[2*RUN_LEN].
- Latency: z rises in the cycle after the edge that samples the RUN_LEN-th equal bit.
- A mode change takes effect on z in the same cycle, with no state change.
- Counter:
  - A detection event is an edge with en=1 where the FSM moves from Z(RUN_LEN-1) to Z_RUN_LEN and mode permits zeros, or from O(RUN_LEN-1) to O_RUN_LEN and mode permits ones.
  - Staying in a saturated state is not a new event.
  - On an event, match_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - Priority: reset > clear_cnt > increment. clear_cnt coincident with an event gives 0.
- Compatibility: with RUN_LEN=2, mode=00, en=1 and clear_cnt=0, the z and State sequences equal the existing 5-state detector's.

Decomposition:
- Shared constants file holds:
  - Mode encodings MODE_BOTH=2'b00, MODE_ZERO=2'b01, MODE_ONE=2'b10.
  - Localparam expressions for IDLE_IDX, Z_IDX(k)=k, O_IDX(k)=RUN_LEN+k.
- State flops use the existing `dff` (Default, D, clk, reset, Q) sub-module, one instance per state bit via generate:
  - Default=1 for bit 0.
  - Default=0 for all other bits.
- No other sub-module. Next-state logic, one-hot check and counter stay in this module.

Test Plan:
- RUN_LEN=2, mode=00, en=1, reset pulsed then w=0,0,0,1,1,0 over six edges:
  - State sequence 00010, 00100, 00100, 01000, 10000, 00010.
  - z = 0,1,1,0,1,0.
  - match_cnt ends at 2.
- RUN_LEN=3, mode=10, w=0,0,0,1,1,1,1:
  - z stays 0 through the zero run; z=1 only after the third 1.
  - match_cnt=1.
  - z_val=1 while z=1.
- en gating, RUN_LEN=2: w=1 with en=1, then en=0 for 5 cycles with w=1, then en=1 with w=1:
  - State holds O1 during the gap.
  - z asserts only after the final enabled edge.
  - match_cnt=1.
- Saturation, CNT_W=2, RUN_LEN=2, mode=00:
  - Alternating pairs 00 11 00 11 00 give match_cnt = 1,2,3,3,3.
  - clear_cnt on the same edge as the 6th event gives 0.
- Reset mid-run: enter O2 (z=1), assert reset with w=1 and en=1:
  - Next cycle State=00001, z=0, match_cnt=0.
  - The following w=1 edge gives O1, not O2.
- Recovery: force State=00110 via the bench, en=0:
  - Next edge State=00001.
  - match_cnt unchanged.

Source files
------------

// File: rtl/run_length_detector_pkg.sv
// Shared encodings and state-index helpers for the run-length detector.
// Zk sits at index k and Ok at index RUN_LEN+k of the one-hot state vector.
package run_length_detector_pkg;

  typedef enum logic [1:0] {
    MODE_BOTH   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_ONE    = 2'b10,
    MODE_EITHER = 2'b11
  } mode_e;

  localparam int unsigned IDLE_IDX = 0;

  function automatic int unsigned z_idx(input int unsigned k);
    return k;
  endfunction

  function automatic int unsigned o_idx(input int unsigned run_len, input int unsigned k);
    return run_len + k;
  endfunction

endpackage

// File: rtl/dff.sv
// Single state flop with a synchronous load of its reset value.
module dff (
  input  logic Default,
  input  logic D,
  input  logic clk,
  input  logic reset,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (reset) Q <= Default;
    else       Q <= D;
  end

endmodule

// File: rtl/run_length_detector.sv
// One-hot Moore detector: z flags a run of RUN_LEN equal bits on w, filtered by mode,
// and match_cnt counts each new saturated run with saturation.
module run_length_detector
  import run_length_detector_pkg::*;
#(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 w,
  input  logic [1:0]           mode,
  input  logic                 clear_cnt,
  output logic                 z,
  output logic                 z_val,
  output logic [2*RUN_LEN:0]   State,
  output logic [CNT_W-1:0]     match_cnt
);

  localparam int unsigned NS     = 2 * RUN_LEN + 1;
  localparam int unsigned ZR_IDX = z_idx(RUN_LEN);
  localparam int unsigned OR_IDX = o_idx(RUN_LEN, RUN_LEN);
  localparam int unsigned ZP_IDX = z_idx(RUN_LEN - 1);
  localparam int unsigned OP_IDX = o_idx(RUN_LEN, RUN_LEN - 1);

  if (RUN_LEN < 2 || RUN_LEN > 16) begin : g_bad_run_len
    $error("run_length_detector: RUN_LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
    $error("run_length_detector: CNT_W must be in 1..16");
  end

  logic [NS-1:0] q;
  logic [NS-1:0] state;
  logic [NS-1:0] nxt;
  logic          legal;
  logic          zero_ok;
  logic          one_ok;
  logic          evt;

  for (genvar i = 0; i < NS; i++) begin : g_state
    dff u_ff (
      .Default (i == 0 ? 1'b1 : 1'b0),
      .D       (nxt[i]),
      .clk     (clk),
      .reset   (reset),
      .Q       (q[i])
    );
  end

  assign state = q;
  assign State = state;
  assign legal = $onehot(state);

  always_comb begin
    nxt = '0;
    if (!legal) begin
      nxt[IDLE_IDX] = 1'b1;
    end else if (!en) begin
      nxt = state;
    end else if (!w) begin
      nxt[z_idx(1)] = state[IDLE_IDX] | (|state[NS-1:RUN_LEN+1]);
      for (int unsigned k = 2; k <= RUN_LEN; k++)
        nxt[z_idx(k)] = state[z_idx(k - 1)];
      // the longest zero run saturates in place
      nxt[ZR_IDX] = nxt[ZR_IDX] | state[ZR_IDX];
    end else begin
      nxt[o_idx(RUN_LEN, 1)] = state[IDLE_IDX] | (|state[RUN_LEN:1]);
      for (int unsigned k = 2; k <= RUN_LEN; k++)
        nxt[o_idx(RUN_LEN, k)] = state[o_idx(RUN_LEN, k - 1)];
      nxt[OR_IDX] = nxt[OR_IDX] | state[OR_IDX];
    end
  end

  assign zero_ok = (mode != MODE_ONE);
  assign one_ok  = (mode != MODE_ZERO);

  // only the step into the saturated state counts, not dwelling there
  assign evt = en & legal &
               ((~w & state[ZP_IDX] & zero_ok) | (w & state[OP_IDX] & one_ok));

  always_ff @(posedge clk) begin
    if (reset)
      match_cnt <= '0;
    else if (clear_cnt)
      match_cnt <= '0;
    else if (evt && match_cnt != '1)
      match_cnt <= match_cnt + CNT_W'(1);
  end

  assign z     = (state[ZR_IDX] & zero_ok) | (state[OR_IDX] & one_ok);
  assign z_val = state[OR_IDX];

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench: two detector instances (RUN_LEN=2/CNT_W=2 and RUN_LEN=3/CNT_W=8)
// driven by directed vectors with hand-computed expected state, z, z_val and count.
module tb_run_length_detector;

  logic       clk;
  logic       rst2, en2, w2, clr2;
  logic [1:0] mode2;
  logic       z2, zv2;
  logic [4:0] st2;
  logic [1:0] cnt2;

  logic       rst3, en3, w3, clr3;
  logic [1:0] mode3;
  logic       z3, zv3;
  logic [6:0] st3;
  logic [7:0] cnt3;

  run_length_detector #(.RUN_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst2), .en(en2), .w(w2), .mode(mode2), .clear_cnt(clr2),
    .z(z2), .z_val(zv2), .State(st2), .match_cnt(cnt2)
  );

  run_length_detector #(.RUN_LEN(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(rst3), .en(en3), .w(w3), .mode(mode3), .clear_cnt(clr3),
    .z(z3), .z_val(zv3), .State(st3), .match_cnt(cnt3)
  );

  typedef struct {
    bit         sel;
    int         due;
    logic [6:0] st;
    logic       z;
    logic       zv;
    logic [7:0] cnt;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] IDLE = 7'b0000001;
  localparam logic [6:0] Z1   = 7'b0000010;
  localparam logic [6:0] Z2   = 7'b0000100;
  localparam logic [6:0] Z3   = 7'b0001000;
  localparam logic [6:0] A_O1 = 7'b0001000;
  localparam logic [6:0] A_O2 = 7'b0010000;
  localparam logic [6:0] B_O1 = 7'b0010000;
  localparam logic [6:0] B_O2 = 7'b0100000;
  localparam logic [6:0] B_O3 = 7'b1000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_exp(input bit sel, input logic [6:0] est, input logic ez,
                          input logic ezv, input logic [7:0] ecnt, input string nm);
    exp_t x;
    x.sel = sel; x.due = cyc + 1; x.st = est; x.z = ez; x.zv = ezv; x.cnt = ecnt; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic step(input bit sel, input logic r, input logic e, input logic wv,
                      input logic [1:0] md, input logic c, input logic [6:0] est,
                      input logic ez, input logic ezv, input logic [7:0] ecnt, input string nm);
    @(negedge clk);
    if (!sel) begin
      rst2 = r; en2 = e; w2 = wv; mode2 = md; clr2 = c;
    end else begin
      rst3 = r; en3 = e; w3 = wv; mode3 = md; clr3 = c;
    end
    push_exp(sel, est, ez, ezv, ecnt, nm);
  endtask

  // monitor: compares every expectation that falls due after this edge
  initial begin
    exp_t       m;
    logic [6:0] ast;
    logic       az, azv;
    logic [7:0] acnt;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].due == cyc) begin
        m = q.pop_front();
        if (!m.sel) begin
          ast = {2'b00, st2}; az = z2; azv = zv2; acnt = {6'b0, cnt2};
        end else begin
          ast = st3; az = z3; azv = zv3; acnt = cnt3;
        end
        checks++;
        if (ast !== m.st || az !== m.z || azv !== m.zv || acnt !== m.cnt) begin
          errors++;
          $display("FAIL %s: got state=%b z=%b z_val=%b cnt=%0d, expected state=%b z=%b z_val=%b cnt=%0d",
                   m.nm, ast, az, azv, acnt, m.st, m.z, m.zv, m.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst2 = 1'b1; en2 = 1'b0; w2 = 1'b0; mode2 = 2'b00; clr2 = 1'b0;
    rst3 = 1'b1; en3 = 1'b0; w3 = 1'b0; mode3 = 2'b10; clr3 = 1'b0;

    // basic sequence, RUN_LEN=2, mode both
    step(0, 1, 1, 0, 2'b00, 0, IDLE, 0, 0, 0, "t1_reset");
    step(0, 0, 1, 0, 2'b00, 0, Z1,   0, 0, 0, "t1_w0a");
    step(0, 0, 1, 0, 2'b00, 0, Z2,   1, 0, 1, "t1_w0b");
    step(0, 0, 1, 0, 2'b00, 0, Z2,   1, 0, 1, "t1_w0c");
    step(0, 0, 1, 1, 2'b00, 0, A_O1, 0, 0, 1, "t1_w1a");
    step(0, 0, 1, 1, 2'b00, 0, A_O2, 1, 1, 2, "t1_w1b");
    step(0, 0, 1, 0, 2'b00, 0, Z1,   0, 0, 2, "t1_w0d");

    // counter saturation at 3 with CNT_W=2, then clear coincident with an event
    step(0, 1, 1, 0, 2'b00, 0, IDLE, 0, 0, 0, "sat_reset");
    step(0, 0, 1, 0, 2'b00, 0, Z1,   0, 0, 0, "sat_p1a");
    step(0, 0, 1, 0, 2'b00, 0, Z2,   1, 0, 1, "sat_p1b");
    step(0, 0, 1, 1, 2'b00, 0, A_O1, 0, 0, 1, "sat_p2a");
    step(0, 0, 1, 1, 2'b00, 0, A_O2, 1, 1, 2, "sat_p2b");
    step(0, 0, 1, 0, 2'b00, 0, Z1,   0, 0, 2, "sat_p3a");
    step(0, 0, 1, 0, 2'b00, 0, Z2,   1, 0, 3, "sat_p3b");
    step(0, 0, 1, 1, 2'b00, 0, A_O1, 0, 0, 3, "sat_p4a");
    step(0, 0, 1, 1, 2'b00, 0, A_O2, 1, 1, 3, "sat_p4b");
    step(0, 0, 1, 0, 2'b00, 0, Z1,   0, 0, 3, "sat_p5a");
    step(0, 0, 1, 0, 2'b00, 0, Z2,   1, 0, 3, "sat_p5b");
    step(0, 0, 1, 1, 2'b00, 0, A_O1, 0, 0, 3, "sat_p6a");
    step(0, 0, 1, 1, 2'b00, 1, A_O2, 1, 1, 0, "sat_clear_on_event");

    // mode change with state held
    step(0, 0, 0, 1, 2'b01, 0, A_O2, 0, 1, 0, "mode_zero_masks_ones");
    step(0, 0, 0, 1, 2'b10, 0, A_O2, 1, 1, 0, "mode_one_passes_ones");

    // reset in the middle of a saturated run
    step(0, 1, 1, 1, 2'b00, 0, IDLE, 0, 0, 0, "midrun_reset");
    step(0, 0, 1, 1, 2'b00, 0, A_O1, 0, 0, 0, "midrun_restart_o1");

    // enable gating
    step(0, 1, 1, 0, 2'b00, 0, IDLE, 0, 0, 0, "en_reset");
    step(0, 0, 1, 1, 2'b00, 0, A_O1, 0, 0, 0, "en_first_one");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 1, 2'b00, 0, A_O1, 0, 0, 0, "en_hold");
    step(0, 0, 1, 1, 2'b00, 0, A_O2, 1, 1, 1, "en_resume");

    // illegal-state recovery with en low; counter must hold
    @(negedge clk);
    rst2 = 1'b0; en2 = 1'b0; w2 = 1'b1; mode2 = 2'b00; clr2 = 1'b0;
    force dut2.state = 5'b00110;
    push_exp(0, IDLE, 0, 0, 1, "recover_to_idle");
    @(posedge clk);
    #1;
    release dut2.state;
    step(0, 0, 1, 0, 2'b00, 0, Z1,   0, 0, 1, "recover_then_w0");
    step(0, 0, 0, 0, 2'b00, 1, Z1,   0, 0, 0, "clear_with_en_low");

    // RUN_LEN=3, ones only
    step(1, 1, 1, 0, 2'b10, 0, IDLE, 0, 0, 0, "r3_reset");
    step(1, 0, 1, 0, 2'b10, 0, Z1,   0, 0, 0, "r3_z1");
    step(1, 0, 1, 0, 2'b10, 0, Z2,   0, 0, 0, "r3_z2");
    step(1, 0, 1, 0, 2'b10, 0, Z3,   0, 0, 0, "r3_z3_masked");
    step(1, 0, 1, 1, 2'b10, 0, B_O1, 0, 0, 0, "r3_o1");
    step(1, 0, 1, 1, 2'b10, 0, B_O2, 0, 0, 0, "r3_o2");
    step(1, 0, 1, 1, 2'b10, 0, B_O3, 1, 1, 1, "r3_o3_detect");
    step(1, 0, 1, 1, 2'b10, 0, B_O3, 1, 1, 1, "r3_o3_stay");
    step(1, 0, 1, 0, 2'b00, 0, Z1,   0, 0, 1, "r3_both_z1");
    step(1, 0, 1, 0, 2'b00, 0, Z2,   0, 0, 1, "r3_both_z2");
    step(1, 0, 1, 0, 2'b00, 0, Z3,   1, 0, 2, "r3_both_z3_detect");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
